// File: rtl/param_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : param_fifo_if
//  Brief    : Handshake/status bundle between a FIFO user and param_fifo.
//  Revision : 1.0  initial release
// ============================================================================
interface param_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic               clr;
    logic               write;
    logic               read;
    logic [WIDTH-1:0]   iData;
    logic [WIDTH-1:0]   oData;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
    logic [c_cnt_w-1:0] count;
    logic               overflow;
    logic               underflow;

    // User side: issues requests and data, observes status
    modport master (
        output clr, write, read, iData,
        input  oData, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    // FIFO side
    modport slave (
        input  clr, write, read, iData,
        output oData, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : param_fifo
//  Brief    : Parameterised synchronous FIFO with occupancy flags, sticky
//             overflow/underflow, synchronous clear and optional FWFT read.
//  Revision : 1.0  initial release
// ============================================================================
module param_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  wire logic     CLK,
    input  wire logic     RSTn,
    param_fifo_if.slave   bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af    = c_cnt_w'(AF_LEVEL);
    localparam logic [c_cnt_w-1:0] c_ae    = c_cnt_w'(AE_LEVEL);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               full_w, empty_w, wr_acc_w, rd_acc_w;

    assign full_w  = (count_q == c_depth);
    assign empty_w = (count_q == '0);

    // Acceptance decisions and next-state for pointers, occupancy and sticky flags
    always_comb begin
        rd_acc_w = bus.read & ~empty_w & ~bus.clr;
        // A read in the same cycle frees a slot, so a write at full still lands
        wr_acc_w = bus.write & (~full_w | rd_acc_w) & ~bus.clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (bus.clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc_w) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
            if (rd_acc_w) rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
            if (wr_acc_w && !rd_acc_w) count_d = count_q + c_cnt_w'(1);
            if (rd_acc_w && !wr_acc_w) count_d = count_q - c_cnt_w'(1);
            if (bus.write && full_w && !bus.read) ovf_d = 1'b1;
            if (bus.read && empty_w) unf_d = 1'b1;
        end
    end

    // Control state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; contents are intentionally not reset
    always_ff @(posedge CLK) begin
        if (wr_acc_w) mem_q[wr_ptr_q] <= bus.iData;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible as soon as the FIFO is non-empty
            assign bus.oData = empty_w ? '0 : mem_q[rd_ptr_q];
        end else begin : g_reg_read
            logic [WIDTH-1:0] data_q, data_d;

            // Output register loads the head word only on an accepted read
            always_comb begin
                data_d = data_q;
                if (rd_acc_w) data_d = mem_q[rd_ptr_q];
            end

            // Read data register
            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) data_q <= '0;
                else       data_q <= data_d;
            end

            assign bus.oData = data_q;
        end
    endgenerate

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= c_af);
    assign bus.almost_empty = (count_q <= c_ae);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_fifo
//  Brief    : Self-checking bench for param_fifo (registered and FWFT modes)
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_fifo;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);
    localparam int SW = CW + 14;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    int   vectors    = 0;
    int   miscompares = 0;

    param_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();
    param_fifo_if #(.WIDTH(W), .DEPTH(D)) fbus ();

    param_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut (
        .CLK(CLK), .RSTn(RSTn), .bus(bus)
    );
    param_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut_fwft (
        .CLK(CLK), .RSTn(RSTn), .bus(fbus)
    );

    always #5 CLK = ~CLK;

    // Reference model: a plain queue plus sticky bits and last-read word
    logic [W-1:0] q[$];
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;
    logic [W-1:0] m_od  = '0;

    function automatic logic [SW-1:0] exp_status();
        int n = q.size();
        return {CW'(n), n == D, n == 0, n >= 6, n <= 2, m_ovf, m_unf, m_od};
    endfunction

    function automatic logic [SW-1:0] act_status();
        return {bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                bus.overflow, bus.underflow, bus.oData};
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_od  = '0;
    endfunction

    // Drive one cycle of requests, advance the model across the edge, settle
    task automatic apply(input logic c, input logic w, input logic r, input logic [W-1:0] d);
        logic do_rd, do_wr;
        bus.clr = c; bus.write = w; bus.read = r; bus.iData = d;
        @(posedge CLK);
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            do_rd = r && (q.size() > 0);
            do_wr = w && ((q.size() < D) || do_rd);
            if (w && q.size() == D && !r) m_ovf = 1'b1;
            if (r && q.size() == 0)       m_unf = 1'b1;
            if (do_rd) m_od = q.pop_front();
            if (do_wr) q.push_back(d);
        end
        #1;
        bus.clr = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (act_status() !== {CW'(0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_status: got %h want %h", act_status(),
                     {CW'(0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        end
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            apply(1'b0, 1'b1, 1'b0, W'(i));
            vectors++;
            if (act_status() !== exp_status() || bus.count !== CW'(i)) begin
                miscompares++;
                $display("FAIL fill_status[%0d]: got %h want %h", i, act_status(), exp_status());
            end
        end
        apply(1'b0, 1'b1, 1'b0, 8'h99);
        vectors++;
        if (bus.overflow !== 1'b1 || bus.count !== CW'(8) || act_status() !== exp_status()) begin
            miscompares++;
            $display("FAIL fill_overflow: got %h want %h", act_status(), exp_status());
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            apply(1'b0, 1'b0, 1'b1, '0);
            vectors++;
            if (bus.oData !== W'(i) || act_status() !== exp_status()) begin
                miscompares++;
                $display("FAIL drain_data[%0d]: got %h want %h", i, act_status(), exp_status());
            end
        end
        apply(1'b0, 1'b0, 1'b1, '0);
        vectors++;
        if (bus.underflow !== 1'b1 || bus.oData !== 8'h08 || bus.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_underflow: got unf=%b od=%h empty=%b want 1 08 1",
                     bus.underflow, bus.oData, bus.empty);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] wdat = 8'h10;
        logic [W-1:0] rexp = 8'h10;
        apply(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 1'b0, wdat);
            wdat++;
        end
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b1, 1'b1, wdat);
            wdat++;
            vectors++;
            if (bus.oData !== rexp || bus.count !== CW'(4) || bus.overflow !== 1'b0 ||
                bus.underflow !== 1'b0 || act_status() !== exp_status()) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got %h want od=%h cnt=4 model=%h",
                         i, act_status(), rexp, exp_status());
            end
            rexp++;
        end
    endtask

    task automatic test_boundary();
        apply(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) apply(1'b0, 1'b1, 1'b0, W'($urandom));
        apply(1'b0, 1'b1, 1'b1, 8'h77);
        vectors++;
        if (bus.count !== CW'(8) || bus.overflow !== 1'b0 || act_status() !== exp_status()) begin
            miscompares++;
            $display("FAIL boundary_full_rw: got %h want %h", act_status(), exp_status());
        end
        apply(1'b1, 1'b0, 1'b0, '0);
        apply(1'b0, 1'b1, 1'b1, 8'h5A);
        vectors++;
        if (bus.count !== CW'(1) || bus.underflow !== 1'b1 || act_status() !== exp_status()) begin
            miscompares++;
            $display("FAIL boundary_empty_rw: got %h want %h", act_status(), exp_status());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, W'($urandom));
            vectors++;
            if (act_status() !== exp_status()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h", i, act_status(), exp_status());
            end
        end
    endtask

    task automatic test_clr_reset();
        apply(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 9; i++) apply(1'b0, 1'b1, 1'b0, W'(8'hC0 + i));
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b1, '0);
        vectors++;
        if (bus.count !== CW'(5) || bus.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_setup: got cnt=%0d ovf=%b want 5 1", bus.count, bus.overflow);
        end
        apply(1'b1, 1'b1, 1'b0, 8'h55);
        vectors++;
        if (act_status() !== exp_status() || bus.count !== CW'(0) || bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_flush: got %h want %h", act_status(), exp_status());
        end
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b0, W'(8'hE1 + i));
        apply(1'b0, 1'b1, 1'b1, 8'hE4);
        bus.write = 1'b1; bus.read = 1'b1; bus.iData = 8'hE5;
        #2;
        RSTn = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (act_status() !== {CW'(0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", act_status(),
                     {CW'(0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        end
        @(negedge CLK);
        RSTn = 1'b1;
        apply(1'b0, 1'b1, 1'b1, 8'h3C);
        vectors++;
        if (act_status() !== exp_status() || bus.count !== CW'(1) || bus.underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset: got %h want %h", act_status(), exp_status());
        end
    endtask

    task automatic test_fwft();
        logic [W-1:0] v[3];
        fbus.write = 1'b1; fbus.iData = 8'hA5;
        @(posedge CLK); #1;
        fbus.write = 1'b0;
        vectors++;
        if (fbus.oData !== 8'hA5 || fbus.empty !== 1'b0) begin
            miscompares++;
            $display("FAIL fwft_first: got od=%h empty=%b want a5 0", fbus.oData, fbus.empty);
        end
        fbus.read = 1'b1;
        @(posedge CLK); #1;
        fbus.read = 1'b0;
        vectors++;
        if (fbus.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL fwft_read_empty: got empty=%b want 1", fbus.empty);
        end
        for (int i = 0; i < 3; i++) begin
            v[i] = W'($urandom);
            fbus.write = 1'b1; fbus.iData = v[i];
            @(posedge CLK); #1;
            fbus.write = 1'b0;
            vectors++;
            if (fbus.oData !== v[0]) begin
                miscompares++;
                $display("FAIL fwft_head_hold[%0d]: got %h want %h", i, fbus.oData, v[0]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            fbus.read = 1'b1;
            @(posedge CLK); #1;
            fbus.read = 1'b0;
            vectors++;
            if (fbus.oData !== v[i] || fbus.count !== CW'(3 - i)) begin
                miscompares++;
                $display("FAIL fwft_advance[%0d]: got od=%h cnt=%0d want %h %0d",
                         i, fbus.oData, fbus.count, v[i], 3 - i);
            end
        end
    endtask

    initial begin
        bus.clr = 1'b0;  bus.write = 1'b0;  bus.read = 1'b0;  bus.iData = '0;
        fbus.clr = 1'b0; fbus.write = 1'b0; fbus.read = 1'b0; fbus.iData = '0;
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_boundary();
        test_random();
        test_clr_reset();
        test_fwft();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
